// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared tags, default parameters, boost FSM encodings and response record.
package dmem_port_arbiter_pkg;
   localparam logic TAG_IF = 1'b0;
   localparam logic TAG_DM = 1'b1;
   localparam int RD_LAT_DEF = 1;
   localparam int STARVE_MAX_DEF = 4;
   localparam logic PRI_DM = 1'b0;
   localparam logic BOOST_IF = 1'b1;
   typedef struct packed {
      logic valid;
      logic tag;
   } rsp_t;
endpackage

// File: rtl/dmem_rsp_pipe.sv
// dmem_rsp_pipe: DEPTH-deep {valid, tag} shift register marking which requester owns each returning read.
module dmem_rsp_pipe
   import dmem_port_arbiter_pkg::*;
#(
   parameter int DEPTH = RD_LAT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic valid_i,
   input  logic tag_i,
   output logic valid_o,
   output logic tag_o
);
   rsp_t [DEPTH-1:0] pipe_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= '{valid: valid_i, tag: tag_i};
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end
   assign valid_o = pipe_q[DEPTH-1].valid;
   assign tag_o = pipe_q[DEPTH-1].tag;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between fetch and load/store with a fetch starvation guard.
// Defining DMEM_ARB_STAT_EN adds saturating conflict and boost-entry counters.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int RD_LAT = RD_LAT_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [3:0]  dm_be_n_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_gnt_o,
   output logic        dm_rvalid_o,
   output logic [31:0] dm_rdata_o,
`ifdef DMEM_ARB_STAT_EN
   output logic [31:0] stat_conflict_o,
   output logic [15:0] stat_boost_o,
`endif
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_n_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i
);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);
   logic       state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       boost, sel_if, sel_dm, rsp_valid, rsp_tag;
   assign boost = state_q == BOOST_IF;
   assign sel_if = if_req_i & (~dm_req_i | boost);
   assign sel_dm = dm_req_i & ~sel_if;
   assign mem_req_o = sel_if | sel_dm;
   assign mem_we_o = sel_dm & dm_we_i;
   assign mem_be_n_o = sel_dm ? dm_be_n_i : 4'b0000;
   assign mem_addr_o = sel_if ? if_addr_i : sel_dm ? dm_addr_i : 32'h0;
   assign mem_wdata_o = sel_dm ? dm_wdata_i : 32'h0;
   assign if_gnt_o = sel_if & mem_ready_i;
   assign dm_gnt_o = sel_dm & mem_ready_i;
   // A grant or a withdrawn fetch request ends the starvation run; the counter rests at STARVE_MAX while boosted.
   always_comb begin
      state_d = state_q;
      starve_d = starve_q;
      if (if_gnt_o || !if_req_i) begin
         state_d = PRI_DM;
         starve_d = '0;
      end else if (state_q == PRI_DM) begin
         starve_d = starve_q + 4'd1;
         state_d = (starve_d == SMAX) ? BOOST_IF : PRI_DM;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PRI_DM;
         starve_q <= '0;
      end else begin
         state_q <= state_d;
         starve_q <= starve_d;
      end
   end
   dmem_rsp_pipe #(.DEPTH(RD_LAT)) u_rsp_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (mem_req_o & mem_ready_i & ~mem_we_o),
      .tag_i   (sel_dm ? TAG_DM : TAG_IF),
      .valid_o (rsp_valid),
      .tag_o   (rsp_tag)
   );
   assign if_rvalid_o = rsp_valid & (rsp_tag == TAG_IF);
   assign dm_rvalid_o = rsp_valid & (rsp_tag == TAG_DM);
   assign if_rdata_o = mem_rdata_i;
   assign dm_rdata_o = mem_rdata_i;
`ifdef DMEM_ARB_STAT_EN
   logic [31:0] conflict_q;
   logic [15:0] boost_cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_q <= '0;
         boost_cnt_q <= '0;
      end else begin
         if (if_req_i && dm_req_i && !(&conflict_q)) conflict_q <= conflict_q + 32'd1;
         if (!boost && state_d == BOOST_IF && !(&boost_cnt_q)) boost_cnt_q <= boost_cnt_q + 16'd1;
      end
   end
   assign stat_conflict_o = conflict_q;
   assign stat_boost_o = boost_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random stimulus checked against a starvation/response reference model.
module tb_dmem_port_arbiter;
   localparam int LAT = 3;
   localparam int SMAX = 4;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_i, dm_req_i, dm_we_i, mem_ready_i;
   logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
   logic [3:0]  dm_be_n_i;
   logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o;
   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_n_o;
`ifdef DMEM_ARB_STAT_EN
   logic [31:0] stat_conflict_o;
   logic [15:0] stat_boost_o;
`endif
   always #5 clk = ~clk;
   dmem_port_arbiter #(.RD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_rvalid_o (if_rvalid_o),
      .if_rdata_o  (if_rdata_o),
      .dm_req_i    (dm_req_i),
      .dm_we_i     (dm_we_i),
      .dm_be_n_i   (dm_be_n_i),
      .dm_addr_i   (dm_addr_i),
      .dm_wdata_i  (dm_wdata_i),
      .dm_gnt_o    (dm_gnt_o),
      .dm_rvalid_o (dm_rvalid_o),
      .dm_rdata_o  (dm_rdata_o),
`ifdef DMEM_ARB_STAT_EN
      .stat_conflict_o (stat_conflict_o),
      .stat_boost_o    (stat_boost_o),
`endif
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_be_n_o  (mem_be_n_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ready_i (mem_ready_i),
      .mem_rdata_i (mem_rdata_i)
   );
   typedef struct {
      int due;
      bit tag;
   } exp_t;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   denied = 0;
   longint n_conflict = 0;
   int   n_boost = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit we,
                        input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd, input bit rdy);
      if_req_i = ir;
      if_addr_i = ia;
      dm_req_i = dr;
      dm_we_i = we;
      dm_be_n_i = be;
      dm_addr_i = da;
      dm_wdata_i = wd;
      mem_ready_i = rdy;
      mem_rdata_i = $urandom;
   endtask
   task automatic model_reset();
      q.delete();
      denied = 0;
      n_conflict = 0;
      n_boost = 0;
   endtask
   // One cycle: check outputs mid-cycle against the model, then advance the model to the next cycle.
   task automatic step(output bit ig, output bit dg);
      bit bst, sif, sdm, rv, rt;
      @(negedge clk);
      bst = denied >= SMAX;
      sif = if_req_i && (!dm_req_i || bst);
      sdm = dm_req_i && !sif;
      ig = sif && mem_ready_i;
      dg = sdm && mem_ready_i;
      chk("if_gnt", if_gnt_o, ig);
      chk("dm_gnt", dm_gnt_o, dg);
      chk("mem_req", mem_req_o, sif || sdm);
      chk("mem_we", mem_we_o, sdm && dm_we_i);
      chk("mem_be_n", mem_be_n_o, sdm ? dm_be_n_i : 4'h0);
      chk("mem_addr", mem_addr_o, sif ? if_addr_i : sdm ? dm_addr_i : 32'h0);
      if (sdm) chk("mem_wdata", mem_wdata_o, dm_wdata_i);
      rv = q.size() > 0 && q[0].due == cyc;
      rt = rv && q[0].tag;
      chk("if_rvalid", if_rvalid_o, rv && !rt);
      chk("dm_rvalid", dm_rvalid_o, rv && rt);
      if (rv && !rt) chk("if_rdata", if_rdata_o, mem_rdata_i);
      if (rv && rt) chk("dm_rdata", dm_rdata_o, mem_rdata_i);
      if (rv) void'(q.pop_front());
`ifdef DMEM_ARB_STAT_EN
      chk("stat_conflict", stat_conflict_o, 32'(n_conflict));
      chk("stat_boost", stat_boost_o, 32'(n_boost));
      if (if_req_i && dm_req_i && n_conflict < 64'hFFFF_FFFF) n_conflict++;
`endif
      if ((ig || dg) && !(sdm && dm_we_i)) q.push_back('{due: cyc + LAT, tag: sdm});
      denied = (ig || !if_req_i) ? 0 : denied + 1;
      if (!bst && denied >= SMAX && n_boost < 65535) n_boost++;
      @(posedge clk);
      #1;
      cyc++;
   endtask
   bit ig, dg, ip, dp, dwe;
   int first;
   logic [31:0] ia, da, dwd;
   logic [3:0]  dbe;
   initial begin
      drive(0, 0, 0, 0, 4'hF, 0, 0, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_rvalid", if_rvalid_o, 0);
      chk("rst_dm_rvalid", dm_rvalid_o, 0);
      rst_n = 1'b1;
      // fetch-only read
      drive(1, 32'h100, 0, 0, 4'hF, 0, 0, 1);
      step(ig, dg);
      chk("fetch_gnt", ig, 1);
      for (int i = 0; i < LAT + 1; i++) begin
         drive(0, 0, 0, 0, 4'hF, 0, 0, 1);
         mem_rdata_i = 32'hDEADBEEF;
         step(ig, dg);
      end
      // both held high: fetch must get through after SMAX denied cycles
      first = -1;
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h200 + i, 1, 0, 4'hF, 32'h300 + i, 0, 1);
         step(ig, dg);
         if (ig && first < 0) first = i;
      end
      chk("starve_gap", first, SMAX);
      for (int i = 0; i < LAT; i++) begin
         drive(0, 0, 0, 0, 4'hF, 0, 0, 1);
         step(ig, dg);
      end
      // store then load
      drive(0, 0, 1, 1, 4'b1110, 32'h40, 32'h12, 1);
      step(ig, dg);
      drive(0, 0, 1, 0, 4'hF, 32'h40, 0, 1);
      step(ig, dg);
      for (int i = 0; i < LAT + 1; i++) begin
         drive(0, 0, 0, 0, 4'hF, 0, 0, 1);
         step(ig, dg);
      end
      // memory stall with both requesting, then ready returns
      for (int i = 0; i < 6; i++) begin
         drive(1, 32'h500, 1, 0, 4'hF, 32'h600, 0, i >= 3);
         step(ig, dg);
      end
      // interleaved reads from alternating requesters
      for (int i = 0; i < 8; i++) begin
         drive(i % 2 == 0, 32'h700 + i, i % 2 == 1, 0, 4'hF, 32'h800 + i, 0, 1);
         step(ig, dg);
      end
      // reset with two reads in flight
      for (int i = 0; i < 2; i++) begin
         drive(i == 0, 32'h900, i == 1, 0, 4'hF, 32'hA00, 0, 1);
         step(ig, dg);
      end
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 4'hF, 0, 0, 1);
      #1;
      chk("midrst_if_rvalid", if_rvalid_o, 0);
      chk("midrst_dm_rvalid", dm_rvalid_o, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < LAT + 2; i++) begin
         drive(1, 32'hB00, 1, 0, 4'hF, 32'hC00, 0, 1);
         step(ig, dg);
         if (i == 0) chk("post_rst_pri_dm", dg, 1);
      end
      // random traffic, requests held until granted
      ip = 0;
      dp = 0;
      drive(0, 0, 0, 0, 4'hF, 0, 0, 1);
      for (int n = 0; n < 3000; n++) begin
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1;
            ia = $urandom;
         end
         if (!dp && $urandom_range(0, 1) == 0) begin
            dp = 1;
            dwe = $urandom_range(0, 2) == 0;
            dbe = 4'($urandom);
            da = $urandom;
            dwd = $urandom;
         end
         drive(ip, ia, dp, dwe, dbe, da, dwd, $urandom_range(0, 3) != 0);
         step(ig, dg);
         if (ig) ip = 0;
         if (dg) dp = 0;
      end
      for (int i = 0; i < LAT + 1; i++) begin
         drive(0, 0, 0, 0, 4'hF, 0, 0, 1);
         step(ig, dg);
      end
      chk("drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: instruction fetch (read-only) and the MEM1 load/store stage.
- Read data returns to the correct requester a fixed RD_LAT cycles after grant. This matches the MEM1 issue / MEM2 consume split, where MEM2 takes rdata as a plain input.
- Fixed data priority, plus a starvation guard so fetch always makes progress.

Parameters:
- RD_LAT, 1, memory read latency in cycles from accepted request to mem_rdata_i valid (legal 1..4)
- STARVE_MAX, 4, consecutive cycles fetch may be denied while requesting before it is forced a grant (legal 1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  32  fetch word address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  32  fetch read data
- dm_req_i  in  1  load/store request
- dm_we_i  in  1  1 = store, 0 = load
- dm_be_n_i  in  4  store byte enables, active-low
- dm_addr_i  in  32  load/store address
- dm_wdata_i  in  32  store data
- dm_gnt_o  out  1  load/store accepted this cycle
- dm_rvalid_o  out  1  load data valid
- dm_rdata_o  out  32  load data, raw word; byte/half extraction stays downstream
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_n_o  out  4  memory byte enables, active-low
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_ready_i  in  1  memory accepts request this cycle
- mem_rdata_i  in  32  memory read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Grant decision (combinational, same cycle):
  - sel_if = if_req_i & (~dm_req_i | boost)
  - sel_dm = dm_req_i & ~sel_if
  - mem_req_o = sel_if | sel_dm
  - mem_* fields are muxed from the selected requester. Fetch drives mem_we_o=0 and mem_be_n_o=4'b0000.
  - x_gnt_o = sel_x & mem_ready_i.
  - Requesters hold their request and fields stable until granted.
- Boost FSM (registered):
  - States: PRI_DM and BOOST_IF.
  - PRI_DM: starve_cnt increments each cycle in which if_req_i=1 and if_gnt_o=0. When starve_cnt reaches STARVE_MAX, go to BOOST_IF.
  - BOOST_IF: boost=1. On if_gnt_o, go to PRI_DM and clear starve_cnt.
  - Any if_gnt_o clears starve_cnt.
  - If if_req_i drops while in BOOST_IF, return to PRI_DM and clear the counter.
- Response pipe:
  - RD_LAT-deep shift register of {valid, tag}. Tag is 0 = fetch, 1 = data.
  - Stage 0 loads valid = mem_req_o & mem_ready_i & ~mem_we_o.
  - At the final stage: if_rvalid_o = valid & ~tag, dm_rvalid_o = valid & tag.
  - if_rdata_o and dm_rdata_o both equal mem_rdata_i; ignore them when the matching rvalid is low.
  - Stores generate no response.
  - Pipe advances every cycle, with no backpressure; requesters must always accept data.
- Throughput: one grant per cycle when mem_ready_i=1. Back-to-back reads from alternating requesters return in grant order.
- mem_ready_i=0: no grant. The pipe still shifts; a bubble enters. starve_cnt still counts a denied fetch.
- Simultaneous requests: data wins unless boost=1.
- Reset values:
  - Pipe cleared; all rvalid=0.
  - FSM in PRI_DM with starve_cnt=0.
  - Combinational outputs are 0 when no request is present.
- Reset mid-operation drops in-flight reads; no rvalid is produced for them.

Optional Feature:
- DMEM_ARB_STAT_EN defined:
  - Adds outputs stat_conflict_o[31:0] (cycles with both requests present) and stat_boost_o[15:0] (entries into BOOST_IF).
  - Both are saturating and reset to 0.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header:
  - Tag constants TAG_IF=0, TAG_DM=1
  - Default RD_LAT and STARVE_MAX
  - Boost FSM state encodings
- One natural sub-module: dmem_rsp_pipe, the RD_LAT-deep {valid, tag} shift register with reset.

Test Plan:
- Fetch-only read, RD_LAT=1: if_req_i=1 at addr 0x100, mem_rdata_i=0xDEADBEEF in the next cycle -> if_gnt_o=1 in cycle 0, if_rvalid_o=1 in cycle 1 with 0xDEADBEEF, dm_rvalid_o=0.
- Simultaneous requests, STARVE_MAX=4, dm_req_i held high: dm granted cycles 0-3, if granted in cycle 4, then dm granted again; starve_cnt=0 after cycle 4.
- Store then load: store be_n=4'b1110 wdata 0x12 -> mem_we_o=1, mem_be_n_o=4'b1110, no dm_rvalid_o; the following load gets dm_rvalid_o exactly RD_LAT cycles after its grant.
- mem_ready_i=0 for 3 cycles with both requesting -> no grants and no rvalid; after ready returns, the boost grant goes to fetch if starve_cnt reached STARVE_MAX.
- RD_LAT=3, interleaved if/dm reads -> rvalid tags appear in grant order, 3 cycles after each grant.
- rst_n asserted while 2 reads are in flight -> all rvalid=0 immediately and stay 0 after release; FSM is in PRI_DM.
